// File: rtl/bid_round_ctrl.sv
// Round controller: opens a bid window, collects one bid per bidder, resolves the highest and debits the winner.
// Keeps the per-bidder balances across rounds; every output comes straight from a flop.
module bid_round_ctrl #(
    parameter int BID_W    = 8,
    parameter int BAL_W    = 16,
    parameter int INIT_BAL = 500,
    parameter int TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2:0]         bid_valid,
    input  logic [3*BID_W-1:0] bid_value,
    output logic [2:0]         bid_ack,
    output logic [2:0]         bid_err,
    output logic               busy,
    output logic               done,
    output logic [1:0]         winner,
    output logic [BID_W-1:0]   win_bid,
    output logic               tie,
    output logic [3*BAL_W-1:0] balance
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_RESOLVE,
        S_REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         cap_q, cap_d;
    logic [BID_W-1:0]   bid_q [3];
    logic [BID_W-1:0]   bid_d [3];
    logic [2:0]         ack_q, ack_d;
    logic [2:0]         err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [1:0]         winner_q, winner_d;
    logic [BID_W-1:0]   win_bid_q, win_bid_d;
    logic               tie_q, tie_d;
    logic [3*BAL_W-1:0] bal_q, bal_d;

    logic [BID_W-1:0]   max_v;
    logic [1:0]         n_max;
    logic [1:0]         win_idx;
    logic [BID_W-1:0]   val;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cap_d     = cap_q;
        bid_d     = bid_q;
        ack_d     = '0;
        err_d     = '0;
        done_d    = 1'b0;
        winner_d  = winner_q;
        win_bid_d = win_bid_q;
        tie_d     = tie_q;
        bal_d     = bal_q;
        max_v     = '0;
        n_max     = '0;
        win_idx   = '0;
        val       = '0;

        // Captured bids are always non-zero, so max_v == 0 means nobody bid.
        for (int i = 0; i < 3; i++) begin
            if (cap_q[i] && (bid_q[i] > max_v)) begin
                max_v = bid_q[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (cap_q[i] && (bid_q[i] == max_v) && (max_v != '0)) begin
                n_max   = n_max + 2'd1;
                win_idx = 2'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    cap_d   = '0;
                    timer_d = TW'(TIMEOUT - 1);
                end
            end
            S_COLLECT: begin
                for (int i = 0; i < 3; i++) begin
                    if (bid_valid[i] && !cap_q[i]) begin
                        val = bid_value[i*BID_W +: BID_W];
                        if ((val != '0) && (BAL_W'(val) <= bal_q[i*BAL_W +: BAL_W])) begin
                            cap_d[i] = 1'b1;
                            bid_d[i] = val;
                            ack_d[i] = 1'b1;
                        end else begin
                            err_d[i] = 1'b1;
                        end
                    end
                end
                if ((&cap_d) || (timer_q == '0)) begin
                    state_d = S_RESOLVE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_RESOLVE: begin
                state_d = S_REPORT;
                done_d  = 1'b1;
                if (max_v == '0) begin
                    winner_d  = 2'd0;
                    win_bid_d = '0;
                    tie_d     = 1'b0;
                end else if (n_max > 2'd1) begin
                    winner_d  = 2'd0;
                    win_bid_d = '0;
                    tie_d     = 1'b1;
                end else begin
                    winner_d  = win_idx + 2'd1;
                    win_bid_d = max_v;
                    tie_d     = 1'b0;
                    bal_d[win_idx*BAL_W +: BAL_W] = bal_q[win_idx*BAL_W +: BAL_W] - BAL_W'(max_v);
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            cap_q     <= '0;
            bid_q     <= '{default: '0};
            ack_q     <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            winner_q  <= '0;
            win_bid_q <= '0;
            tie_q     <= 1'b0;
            bal_q     <= {3{BAL_W'(INIT_BAL)}};
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cap_q     <= cap_d;
            bid_q     <= bid_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            winner_q  <= winner_d;
            win_bid_q <= win_bid_d;
            tie_q     <= tie_d;
            bal_q     <= bal_d;
        end
    end

    assign bid_ack = ack_q;
    assign bid_err = err_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign winner  = winner_q;
    assign win_bid = win_bid_q;
    assign tie     = tie_q;
    assign balance = bal_q;

endmodule

// File: doc/bid_round_ctrl.md
Name: bid_round_ctrl

Overview:
- Round controller for the bids22 auction datapath.
- Opens a bidding window on `start` and collects one bid from each of three bidders (X=0, Y=1, Z=2) through a valid/ack handshake.
- Resolves the highest bid, debits the winner's balance and reports the result.
- Per-bidder balance registers live here and carry over from round to round.

Parameters:
- BID_W, 8: bid value width.
- BAL_W, 16: balance width.
- INIT_BAL, 500: balance loaded into every bidder on reset.
- TIMEOUT, 16: number of COLLECT cycles before the window is forced closed. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request to open a round; sampled only in IDLE.
- bid_valid  in  3  bit i: bidder i presents a bid this cycle.
- bid_value  in  3*BID_W  bidder i's bid at [i*BID_W +: BID_W].
- bid_ack  out  3  bit i: one-cycle pulse, bid accepted.
- bid_err  out  3  bit i: one-cycle pulse, bid rejected.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, result valid.
- winner  out  2  0 = none/tie, 1 = X, 2 = Y, 3 = Z.
- win_bid  out  BID_W  winning bid amount; 0 if no winner.
- tie  out  1  highest captured bid shared by two or more bidders.
- balance  out  3*BAL_W  current balance of bidder i at [i*BAL_W +: BAL_W].

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; all outputs 0 except balance, which is INIT_BAL for all bidders.
  - Applies in any state; an open round is aborted, captured bids discarded, balances restored to INIT_BAL.
- States: IDLE → COLLECT → RESOLVE → REPORT → IDLE. All outputs are registered.
- IDLE:
  - start=1 → COLLECT next cycle; captured flags cleared; timer loaded with TIMEOUT-1.
  - start has no effect in any other state.
- COLLECT, evaluated per bidder i each cycle:
  - Condition: bid_valid[i]=1 and bidder i not yet captured.
  - Accept when 0 < bid_value ≤ balance[i]: capture the value; bid_ack[i]=1 in the next cycle.
  - Otherwise reject: bid_err[i]=1 in the next cycle; the bidder is not captured and may retry.
  - bid_valid from an already-captured bidder is ignored (no ack, no err).
  - Simultaneous valid bids are all evaluated in the same cycle.
  - Exit to RESOLVE when all three are captured (counting captures made this cycle) or timer==0; otherwise timer decrements.
  - A bid presented in the timer==0 cycle is still evaluated; its ack/err is issued in the RESOLVE cycle.
- RESOLVE (1 cycle): find the maximum among captured bids (unsigned compare).
  - No captures → winner=0, win_bid=0, tie=0.
  - Maximum held by ≥2 bidders → tie=1, winner=0, win_bid=0; no debit.
  - Otherwise winner=i+1, win_bid=max, tie=0; balance[i] -= max. Cannot underflow, because accept requires bid ≤ balance.
  - winner/win_bid/tie update at the end of this cycle.
- REPORT (1 cycle):
  - done=1.
  - Updated balance is visible.
  - → IDLE.
- winner, win_bid and tie hold until the RESOLVE of the next round; they are not cleared on start.
- Latency:
  - Start sampled at edge 0 → COLLECT during cycles 1..k → RESOLVE k+1 → done high in cycle k+2.
  - k=1 when all bids arrive in the first COLLECT cycle.
  - k=TIMEOUT on timeout.
- busy is high during cycles 1 through k+2 inclusive.

Test Plan:
- Reset, then start; X=30, Y=50, Z=20, all valid in COLLECT cycle 1 → bid_ack=3'b111 in cycle 2; done in cycle 3; winner=2, win_bid=50, tie=0; balance Y=450, X=Z=500.
- Tie: X=40, Y=40, Z=10 → done with tie=1, winner=0, win_bid=0; all balances unchanged at 500.
- Timeout: only Z bids 7, in COLLECT cycle 3; TIMEOUT=16 → bid_ack[2] pulse; done in cycle 18; winner=3, win_bid=7, Z balance=493.
- Reject and retry, with INIT_BAL=200:
  - X bids 255 → bid_err[0] pulse, no ack.
  - X then bids 0 → bid_err[0].
  - X then bids 150 → bid_ack[0]; after Y=100, Z=90 arrive, winner=1 and X balance=50.
  - Next round X bids 60 → bid_err[0].
- Robustness:
  - start pulsed during COLLECT and REPORT → ignored.
  - reset_n=0 in COLLECT after Y captured 80 → next cycle state IDLE, busy=0, done never pulses, all balances=INIT_BAL.
  - A following round resolves normally.
